// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
//   DATA_W_DEFAULT      default entry width
//   MIN_PREFETCH_DEPTH  smallest buffer that sustains one beat per cycle
//                       at a 1-cycle FIFO read latency
//   data_t              default-width data word
//   lvl_w()             width needed to hold an occupancy of 0..depth
package fifo_stream_pkg;

    localparam int DATA_W_DEFAULT     = 32;
    localparam int MIN_PREFETCH_DEPTH = 3;

    typedef logic [DATA_W_DEFAULT-1:0] data_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_rd_prefetch_buf.sv
// Circular register buffer feeding the stream output.
//   clk, rst         clock, synchronous active-high reset
//   clear            drop all contents and rewind indices
//   push, push_data  write one entry at the tail
//   pop              retire the head entry
//   head_data        entry at the read index
//   count            number of stored entries
module rd_prefetch_buf
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEFAULT,
    parameter int BUF_DEPTH  = 3,
    localparam int LVL_W     = lvl_w(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [LVL_W-1:0]      count
);

    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (push) wr_idx <= wrap_inc(wr_idx);
            if (pop)  rd_idx <= wrap_inc(rd_idx);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !clear) mem[wr_idx] <= push_data;
    end

    assign head_data = mem[rd_idx];

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == FULL_LVL));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Turns the async FIFO read port (rd_en / empty / data one cycle later) into
// a valid/ready stream with a small prefetch buffer. Reads are issued only
// from registered occupancy, so m_ready never reaches fifo_rd_en.
//   rd_clk, rd_rst    clock, synchronous active-high reset
//   fifo_rd_en        read request to the FIFO
//   fifo_rd_empty     FIFO empty flag
//   fifo_rd_data      FIFO data, valid the cycle after an accepted read
//   m_valid, m_ready  stream handshake
//   m_data            stream data (head of buffer)
//   flush             discard buffered and in-flight data
//   buf_level         buffered entries, not counting the in-flight read
module fifo_rd_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEFAULT,
    parameter int BUF_DEPTH  = 3,
    localparam int LVL_W     = lvl_w(BUF_DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    output logic                  fifo_rd_en,
    input  logic                  fifo_rd_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [LVL_W-1:0]      buf_level
);

    generate
        if (BUF_DEPTH < MIN_PREFETCH_DEPTH) begin : g_depth_check
            $error("BUF_DEPTH too small to sustain one beat per cycle");
        end
    endgenerate

    localparam logic [LVL_W:0] DEPTH_LIM = BUF_DEPTH[LVL_W:0];

    logic             inflight;
    logic [LVL_W-1:0] count;
    logic [LVL_W:0]   occupancy;
    logic             push;
    logic             pop;

    // The in-flight word already owns a slot, so reserve it before reading.
    assign occupancy  = {1'b0, count} + {{LVL_W{1'b0}}, inflight};
    assign fifo_rd_en = !rd_rst && !flush && !fifo_rd_empty && (occupancy < DEPTH_LIM);

    // A word landing during a flush belongs to the discarded stream.
    assign push    = inflight && !flush;
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) inflight <= 1'b0;
        else        inflight <= fifo_rd_en;
    end

    rd_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .clear     (flush),
        .push      (push),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (count)
    );

    assign buf_level = count;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        fifo_rd_en;
    logic        fifo_rd_empty;
    logic [31:0] fifo_rd_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        flush = 1'b0;
    logic [1:0]  buf_level;

    int errors = 0;
    int checks = 0;

    logic [31:0] fifo_mem [256];
    int          rd_ptr = 0;
    int          wr_ptr = 0;

    logic [31:0] got     [512];
    int          got_cyc [512];
    int          n_got = 0;
    int          cyc   = 0;

    fifo_rd_stream_adapter #(.DATA_WIDTH(32), .BUF_DEPTH(3)) dut (
        .rd_clk        (rd_clk),
        .rd_rst        (rd_rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .flush         (flush),
        .buf_level     (buf_level)
    );

    always #5 rd_clk = ~rd_clk;

    assign fifo_rd_empty = (rd_ptr == wr_ptr);

    // FIFO model with 1-cycle read latency, plus a log of accepted beats.
    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_rd_empty) begin
            fifo_rd_data <= fifo_mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
        if (!rd_rst && m_valid && m_ready) begin
            got[n_got]     <= m_data;
            got_cyc[n_got] <= cyc;
            n_got          <= n_got + 1;
        end
    end

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_got >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge rd_clk);
        end
        if (n_got >= target) ok = 1'b1;
    endtask

    task automatic test_reset;
        rd_rst  = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) push_word(32'hA1 + k);
        repeat (3) begin
            @(negedge rd_clk);
            checks++;
            if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
            checks++;
            if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
        end
        rd_rst = 1'b0;
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_lat_c0 got=%b exp=0", m_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge rd_clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'hA1 + k)
                begin errors++; $display("FAIL rst_stream[%0d] got v=%b d=%h exp v=1 d=%h", k, m_valid, m_data, 32'hA1 + k); end
        end
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0 || buf_level !== 2'd0)
            begin errors++; $display("FAIL rst_drain got v=%b lvl=%0d exp v=0 lvl=0", m_valid, buf_level); end
    endtask

    task automatic test_backpressure;
        int r0, base;
        bit ok;
        m_ready = 1'b0;
        r0 = rd_ptr;
        for (int k = 0; k < 10; k++) push_word(32'h100 + k);
        repeat (4) @(negedge rd_clk);
        checks++;
        if (m_data !== 32'h100) begin errors++; $display("FAIL bp_hold_mid got=%h exp=100", m_data); end
        repeat (4) @(negedge rd_clk);
        checks++;
        if (rd_ptr - r0 !== 3) begin errors++; $display("FAIL bp_reads got=%0d exp=3", rd_ptr - r0); end
        checks++;
        if (buf_level !== 2'd3) begin errors++; $display("FAIL bp_level got=%0d exp=3", buf_level); end
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL bp_rd_en got=%b exp=0", fifo_rd_en); end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h100)
            begin errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=100", m_valid, m_data); end
        base = n_got;
        m_ready = 1'b1;
        wait_beats(base + 10, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout got=%0d exp=10 beats", n_got - base); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (got[base + k] !== 32'h100 + k || got_cyc[base + k] !== got_cyc[base] + k)
                begin errors++; $display("FAIL bp_order[%0d] got d=%h dc=%0d exp d=%h dc=%0d", k, got[base + k], got_cyc[base + k] - got_cyc[base], 32'h100 + k, k); end
        end
        repeat (3) @(negedge rd_clk);
    endtask

    task automatic test_alternate;
        int base;
        base = n_got;
        for (int k = 0; k < 8; k++) push_word(32'h10 + k);
        for (int i = 0; i < 60 && n_got < base + 8; i++) begin
            m_ready = (i % 2 == 0);
            @(negedge rd_clk);
        end
        m_ready = 1'b0;
        repeat (6) @(negedge rd_clk);
        checks++;
        if (n_got - base !== 8) begin errors++; $display("FAIL alt_count got=%0d exp=8", n_got - base); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[base + k] !== 32'h10 + k)
                begin errors++; $display("FAIL alt_order[%0d] got=%h exp=%h", k, got[base + k], 32'h10 + k); end
        end
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL alt_idle got=%b exp=0", m_valid); end
    endtask

    task automatic test_empty_gap;
        int base;
        base = n_got;
        m_ready = 1'b1;
        push_word(32'h20);
        push_word(32'h21);
        repeat (5) @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0 || buf_level !== 2'd0)
            begin errors++; $display("FAIL gap_idle got v=%b lvl=%0d exp v=0 lvl=0", m_valid, buf_level); end
        checks++;
        if (n_got - base !== 2 || got[base] !== 32'h20 || got[base + 1] !== 32'h21)
            begin errors++; $display("FAIL gap_first got n=%0d %h %h exp n=2 20 21", n_got - base, got[base], got[base + 1]); end
        push_word(32'h30);
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL gap_c1 got=%b exp=0", m_valid); end
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h30)
            begin errors++; $display("FAIL gap_refill got v=%b d=%h exp v=1 d=30", m_valid, m_data); end
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL gap_end got=%b exp=0", m_valid); end
    endtask

    task automatic test_flush;
        int base, r0;
        bit ok;
        m_ready = 1'b0;
        r0 = rd_ptr;
        for (int k = 0; k < 4; k++) push_word(32'h40 + k);
        repeat (3) @(negedge rd_clk);
        checks++;
        if (buf_level !== 2'd2) begin errors++; $display("FAIL fl_pre_level got=%0d exp=2", buf_level); end
        base = n_got;
        flush = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL fl_rd_en got=%b exp=0", fifo_rd_en); end
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0 || buf_level !== 2'd0)
            begin errors++; $display("FAIL fl_clear got v=%b lvl=%0d exp v=0 lvl=0", m_valid, buf_level); end
        checks++;
        if (rd_ptr - r0 !== 3) begin errors++; $display("FAIL fl_reads got=%0d exp=3", rd_ptr - r0); end
        flush   = 1'b0;
        m_ready = 1'b1;
        wait_beats(base + 1, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fl_timeout got=%0d exp=1 beat", n_got - base); end
        repeat (3) @(negedge rd_clk);
        checks++;
        if (n_got - base !== 1 || got[base] !== 32'h43)
            begin errors++; $display("FAIL fl_next got n=%0d d=%h exp n=1 d=43", n_got - base, got[base]); end
    endtask

    task automatic test_reset_midstream;
        int base, r0;
        bit ok;
        m_ready = 1'b1;
        r0 = rd_ptr;
        base = n_got;
        for (int k = 0; k < 8; k++) push_word(32'h50 + k);
        repeat (4) @(negedge rd_clk);
        checks++;
        if (n_got - base !== 2) begin errors++; $display("FAIL mr_pre got=%0d exp=2", n_got - base); end
        rd_rst = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mr_rd_en got=%b exp=0", fifo_rd_en); end
        @(negedge rd_clk);
        checks++;
        if (m_valid !== 1'b0 || buf_level !== 2'd0)
            begin errors++; $display("FAIL mr_clear got v=%b lvl=%0d exp v=0 lvl=0", m_valid, buf_level); end
        checks++;
        if (rd_ptr - r0 !== 4) begin errors++; $display("FAIL mr_reads got=%0d exp=4", rd_ptr - r0); end
        rd_rst = 1'b0;
        base = n_got;
        wait_beats(base + 4, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mr_timeout got=%0d exp=4 beats", n_got - base); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got[base + k] !== 32'h54 + k)
                begin errors++; $display("FAIL mr_order[%0d] got=%h exp=%h", k, got[base + k], 32'h54 + k); end
        end
        repeat (3) @(negedge rd_clk);
        checks++;
        if (n_got - base !== 4) begin errors++; $display("FAIL mr_count got=%0d exp=4", n_got - base); end
    endtask

    initial begin
        test_reset;
        repeat (2) @(negedge rd_clk);
        test_backpressure;
        test_alternate;
        test_empty_gap;
        repeat (2) @(negedge rd_clk);
        test_flush;
        repeat (2) @(negedge rd_clk);
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
